// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES inverse round path.
// Row-major 128-bit state: [127:96] row 0 ... [31:0] row 3, column 0 in the MS byte.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } aes_fsm_e;

    localparam int AES_NR_MAX = 14;

    localparam int ROW_W   = 32;
    localparam int ROW0_HI = 127;
    localparam int ROW1_HI = 95;
    localparam int ROW2_HI = 63;
    localparam int ROW3_HI = 31;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Row r rotates right by r bytes.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [31:0] r1, r2, r3;
        r1 = s[ROW1_HI -: ROW_W];
        r2 = s[ROW2_HI -: ROW_W];
        r3 = s[ROW3_HI -: ROW_W];
        return {s[ROW0_HI -: ROW_W],
                r1[7:0],  r1[31:8],
                r2[15:0], r2[31:16],
                r3[23:0], r3[31:24]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[ROW0_HI - 8*c -: 8];
            a1 = s[ROW1_HI - 8*c -: 8];
            a2 = s[ROW2_HI - 8*c -: 8];
            a3 = s[ROW3_HI - 8*c -: 8];
            o[ROW0_HI - 8*c -: 8] = gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3);
            o[ROW1_HI - 8*c -: 8] = gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3);
            o[ROW2_HI - 8*c -: 8] = gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3);
            o[ROW3_HI - 8*c -: 8] = gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational 8-bit AES inverse S-box.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Row 0 of the table sits in the MS bits, so entry x lives at index 255-x (= ~x).
    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = INV_SBOX[~a];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one block per pass through IDLE/ROUND/FINAL/DONE.
// Optional AES_STATE_ZEROIZE_EN: clear the state on output handshake and mask out_block when idle.
module aes_inv_cipher_core
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    if ((NR != 10 && NR != 12 && NR != 14) || NR > AES_NR_MAX) begin : g_bad_nr
        $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX = 4'(NR);

    aes_fsm_e     fsm;
    logic [127:0] state_q;
    logic [3:0]   ctr;

    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] key_add;
    logic [127:0] round_next;

    assign isr = inv_shift_rows(state_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a (isr[8*i +: 8]),
            .y (isb[8*i +: 8])
        );
    end

    // FINAL uses key_add directly; ROUND additionally runs InvMixColumns.
    assign key_add    = isb ^ rk;
    assign round_next = inv_mix_columns(key_add);

    // rk_idx is registered one state ahead so it is valid from the first cycle of each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            state_q   <= '0;
            ctr       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            rk_idx    <= NR_IDX;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q  <= in_block ^ rk;
                        ctr      <= NR_IDX - 4'd1;
                        rk_idx   <= NR_IDX - 4'd1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q <= round_next;
                    if (ctr == 4'd1) begin
                        rk_idx <= 4'd0;
                        fsm    <= S_FINAL;
                    end else begin
                        ctr    <= ctr - 4'd1;
                        rk_idx <= ctr - 4'd1;
                    end
                end
                S_FINAL: begin
                    state_q   <= key_add;
                    out_valid <= 1'b1;
                    rk_idx    <= NR_IDX;
                    fsm       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
`ifdef AES_STATE_ZEROIZE_EN
                        state_q <= '0;
`endif
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

`ifdef AES_STATE_ZEROIZE_EN
    assign out_block = out_valid ? state_q : '0;
`else
    assign out_block = state_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed known-answer bench: FIPS-197 C.1/C.3/B vectors through NR=10 and NR=14 cores.
module tb_aes_inv_cipher_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv10, ir10, ov10, ordy10, busy10;
    logic [127:0] ib10, rk10, ob10;
    logic [3:0]   idx10;
    logic         iv14, ir14, ov14, ordy14, busy14;
    logic [127:0] ib14, rk14, ob14;
    logic [3:0]   idx14;

    logic [127:0] rks10 [0:15];
    logic [127:0] rks14 [0:15];
    logic [7:0]   sbox  [0:255];

    int n_cmp = 0;
    int n_err = 0;

    assign rk10 = rks10[idx10];
    assign rk14 = rks14[idx14];

    aes_inv_cipher_core #(.NR(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10), .in_block(ib10),
        .rk_idx(idx10), .rk(rk10), .out_valid(ov10), .out_ready(ordy10),
        .out_block(ob10), .busy(busy10)
    );

    aes_inv_cipher_core #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .in_block(ib14),
        .rk_idx(idx14), .rk(rk14), .out_valid(ov14), .out_ready(ordy14),
        .out_block(ob14), .busy(busy14)
    );

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // Forward S-box from first principles: GF inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Column-major (FIPS byte order) <-> row-major; the transpose is its own inverse.
    function automatic logic [127:0] to_rm(input logic [127:0] cm);
        logic [127:0] rm;
        rm = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rm[127 - 32*r - 8*c -: 8] = cm[127 - 32*c - 8*r -: 8];
        return rm;
    endfunction

    task automatic build_ks(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]  w [0:59];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] kcm;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            kcm = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
            if (nr == 10) rks10[r] = to_rm(kcm);
            else          rks14[r] = to_rm(kcm);
        end
    endtask

    // Accept one block on the NR=10 core and track rk_idx/out_valid edge by edge;
    // out_valid rises on the 10th edge after the accept edge (11 edges counting it).
    task automatic dec10(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        ib10 = to_rm(ct);
        iv10 = 1'b1;
        chk({tag, "_ready"}, 128'(ir10), 128'(1));
        chk({tag, "_idx_idle"}, 128'(idx10), 128'(10));
        tick();
        iv10 = 1'b0;
        for (int j = 0; j < 10; j++) begin
            chk({tag, "_idx"}, 128'(idx10), 128'(9 - j));
            chk({tag, "_ov_early"}, 128'(ov10), 128'(0));
            tick();
        end
        chk({tag, "_ov"}, 128'(ov10), 128'(1));
        chk({tag, "_pt"}, ob10, to_rm(pt));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        iv10 = 1'b0; ib10 = '0; ordy10 = 1'b0;
        iv14 = 1'b0; ib14 = '0; ordy14 = 1'b0;
        build_sbox();
        build_ks({C1_KEY, 128'h0}, 4, 10);
        build_ks(C3_KEY, 8, 14);

        #2;
        chk("rst_in_ready", 128'(ir10), 128'(1));
        chk("rst_out_valid", 128'(ov10), 128'(0));
        chk("rst_busy", 128'(busy10), 128'(0));
        chk("rst_rk_idx", 128'(idx10), 128'(10));
        chk("rst_out_block", ob10, 128'h0);
        chk("rst_rk_idx14", 128'(idx14), 128'(14));
        #10 rst = 1'b0;
        tick();

        // C.1 known answer, then hold it under backpressure
        dec10(C1_CT, PT_STD, "c1");
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_ov", 128'(ov10), 128'(1));
            chk("bp_block", ob10, to_rm(PT_STD));
            chk("bp_in_ready", 128'(ir10), 128'(0));
            chk("bp_busy", 128'(busy10), 128'(1));
        end
        ordy10 = 1'b1;
        tick();
        ordy10 = 1'b0;
        chk("hs_ov", 128'(ov10), 128'(0));
        chk("hs_in_ready", 128'(ir10), 128'(1));
        chk("hs_busy", 128'(busy10), 128'(0));
`ifdef AES_STATE_ZEROIZE_EN
        chk("zero_out_block", ob10, 128'h0);
        chk("zero_state", dut10.state_q, 128'h0);
`else
        chk("keep_out_block", ob10, to_rm(PT_STD));
`endif

        // Back-to-back: in_valid stays high; second block switches key after first completes
        ib10 = to_rm(C1_CT);
        iv10 = 1'b1;
        tick();
        ib10 = to_rm(B_CT);
        n = 0;
        while (!ov10 && n < 30) begin tick(); n++; end
        chk("b2b_first_ov", 128'(ov10), 128'(1));
        chk("b2b_first_pt", ob10, to_rm(PT_STD));
        chk("b2b_first_lat", 128'(n), 128'(10));
        build_ks({B_KEY, 128'h0}, 4, 10);
        ordy10 = 1'b1;
        tick();
        chk("b2b_idle_ready", 128'(ir10), 128'(1));
        tick();
        iv10 = 1'b0;
        chk("b2b_second_acc", 128'(busy10), 128'(1));
        chk("b2b_second_idx", 128'(idx10), 128'(9));
        n = 0;
        while (!ov10 && n < 30) begin tick(); n++; end
        chk("b2b_second_lat", 128'(n), 128'(10));
        chk("b2b_second_pt", ob10, to_rm(B_PT));
        tick();
        ordy10 = 1'b0;
        chk("b2b_end_idle", 128'(ir10), 128'(1));
        build_ks({C1_KEY, 128'h0}, 4, 10);

        // Async reset while a round is in flight
        ib10 = to_rm(C1_CT);
        iv10 = 1'b1;
        tick();
        iv10 = 1'b0;
        n = 0;
        while (idx10 != 4'd5 && n < 30) begin tick(); n++; end
        chk("mid_idx", 128'(idx10), 128'(5));
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 128'(ir10), 128'(1));
        chk("mid_rst_ov", 128'(ov10), 128'(0));
        chk("mid_rst_busy", 128'(busy10), 128'(0));
        chk("mid_rst_idx", 128'(idx10), 128'(10));
        #2 rst = 1'b0;
        tick();
        dec10(C1_CT, PT_STD, "c1_after_rst");
        ordy10 = 1'b1;
        tick();
        ordy10 = 1'b0;

        // NR=14, FIPS C.3: out_valid on the 14th edge after the accept edge
        ib14 = to_rm(C3_CT);
        iv14 = 1'b1;
        chk("c3_ready", 128'(ir14), 128'(1));
        tick();
        iv14 = 1'b0;
        for (int j = 0; j < 14; j++) begin
            chk("c3_idx", 128'(idx14), 128'(13 - j));
            chk("c3_ov_early", 128'(ov14), 128'(0));
            tick();
        end
        chk("c3_ov", 128'(ov14), 128'(1));
        chk("c3_pt", ob14, to_rm(PT_STD));
        ordy14 = 1'b1;
        tick();
        ordy14 = 1'b0;
        chk("c3_idle", 128'(ir14), 128'(1));
        chk("c3_idx_idle", 128'(idx14), 128'(14));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
